// File: rtl/miss_refill_arbiter_if.sv
// Cache-miss refill bus: I-cache and D-cache request/fill ports plus the
// shared external memory port, as seen by miss_refill_arbiter.
// "slave" is the arbiter's view; "master" is the view of the caches and
// memory that surround it.
interface miss_refill_arbiter_if #(
  parameter int IDX_W = 2
);
  // I-cache side
  logic             i_ic_req;
  logic [31:0]      i_ic_addr;
  logic             o_ic_fill_we;
  logic [IDX_W-1:0] o_ic_fill_idx;
  logic [31:0]      o_ic_fill_data;
  logic             o_ic_done;
  // D-cache side
  logic             i_dc_req;
  logic             i_dc_we;
  logic [31:0]      i_dc_addr;
  logic [31:0]      i_dc_wdata;
  logic             o_dc_fill_we;
  logic [IDX_W-1:0] o_dc_fill_idx;
  logic [31:0]      o_dc_fill_data;
  logic             o_dc_done;
  // External memory port
  logic             o_mem_req;
  logic             o_mem_we;
  logic [31:0]      o_mem_addr;
  logic [31:0]      o_mem_wdata;
  logic             i_mem_gnt;
  logic             i_mem_rvalid;
  logic [31:0]      i_mem_rdata;

  modport slave (
    input  i_ic_req, i_ic_addr,
    output o_ic_fill_we, o_ic_fill_idx, o_ic_fill_data, o_ic_done,
    input  i_dc_req, i_dc_we, i_dc_addr, i_dc_wdata,
    output o_dc_fill_we, o_dc_fill_idx, o_dc_fill_data, o_dc_done,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
    input  i_mem_gnt, i_mem_rvalid, i_mem_rdata
  );

  modport master (
    output i_ic_req, i_ic_addr,
    input  o_ic_fill_we, o_ic_fill_idx, o_ic_fill_data, o_ic_done,
    output i_dc_req, i_dc_we, i_dc_addr, i_dc_wdata,
    input  o_dc_fill_we, o_dc_fill_idx, o_dc_fill_data, o_dc_done,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
    output i_mem_gnt, i_mem_rvalid, i_mem_rdata
  );
endinterface

// File: rtl/miss_refill_arbiter.sv
// Shared memory-port arbiter for I-cache and D-cache misses.
// D-side wins ties; the owner keeps the port until its transaction is done.
// Line refills issue one word read at a time (one outstanding request) and
// hand each returned word to the owning cache one cycle after it arrives.
// D-side stores are forwarded as a single word-aligned write.
module miss_refill_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = 2
) (
  input  logic                  Clk,
  input  logic                  Rst,
  miss_refill_arbiter_if.slave  bus
);

  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] LINE_MASK  = ~((DATA_W'(LINE_WORDS) * 32'd4) - 32'd1);
  localparam logic [DATA_W-1:0] WORD_MASK  = 32'hFFFF_FFFC;
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_t;

  state_t             state, state_nxt;
  owner_t             owner, owner_nxt;
  logic               op_we, op_we_nxt;
  logic [DATA_W-1:0]  base, base_nxt;
  logic [DATA_W-1:0]  wdata, wdata_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;

  // Captured refill word, presented to the owning cache one cycle after rvalid.
  logic               vld_p1;
  logic [IDX_W-1:0]   fill_idx_p1;
  logic [DATA_W-1:0]  fill_data_p1;

  logic               issuing;
  logic               rd_accept;

  assign issuing   = (state == ST_ISSUE);
  assign rd_accept = (state == ST_WAIT) && bus.i_mem_rvalid;

  // Transaction state register: FSM, owner, opcode, line base, store data, word index.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= ST_IDLE;
      owner <= OWN_NONE;
      op_we <= 1'b0;
      base  <= '0;
      wdata <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      op_we <= op_we_nxt;
      base  <= base_nxt;
      wdata <= wdata_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state logic: arbitration in IDLE, grant wait in ISSUE, data wait in WAIT.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    op_we_nxt = op_we;
    base_nxt  = base;
    wdata_nxt = wdata;
    idx_nxt   = idx;
    case (state)
      ST_IDLE: begin
        idx_nxt = '0;
        if (bus.i_dc_req) begin
          owner_nxt = OWN_D;
          op_we_nxt = bus.i_dc_we;
          base_nxt  = bus.i_dc_we ? (bus.i_dc_addr & WORD_MASK) : (bus.i_dc_addr & LINE_MASK);
          wdata_nxt = bus.i_dc_wdata;
          state_nxt = ST_ISSUE;
        end else if (bus.i_ic_req) begin
          owner_nxt = OWN_I;
          op_we_nxt = 1'b0;
          base_nxt  = bus.i_ic_addr & LINE_MASK;
          wdata_nxt = '0;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (bus.i_mem_gnt) begin
          state_nxt = op_we ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.i_mem_rvalid) begin
          if (idx == LAST_IDX) begin
            state_nxt = ST_DONE;
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = ST_ISSUE;
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        owner_nxt = OWN_NONE;
        idx_nxt   = '0;
      end
      default: begin
        state_nxt = ST_IDLE;
        owner_nxt = OWN_NONE;
        idx_nxt   = '0;
      end
    endcase
  end

  // ---- stage p1: registered refill word ----
  // Capture each returned word with its line index; hold data between fills.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      vld_p1       <= 1'b0;
      fill_idx_p1  <= '0;
      fill_data_p1 <= '0;
    end else begin
      vld_p1 <= rd_accept;
      if (rd_accept) begin
        fill_idx_p1  <= idx;
        fill_data_p1 <= bus.i_mem_rdata;
      end
    end
  end

  // Memory port is only driven while a request is being offered.
  assign bus.o_mem_req   = issuing;
  assign bus.o_mem_we    = issuing && op_we;
  assign bus.o_mem_addr  = issuing ? (base + (DATA_W'(idx) << 2)) : '0;
  assign bus.o_mem_wdata = (issuing && op_we) ? wdata : '0;

  // Fill and done outputs reach only the current owner.
  assign bus.o_ic_fill_we   = vld_p1 && (owner == OWN_I);
  assign bus.o_ic_fill_idx  = (owner == OWN_I) ? fill_idx_p1 : '0;
  assign bus.o_ic_fill_data = (owner == OWN_I) ? fill_data_p1 : '0;
  assign bus.o_ic_done      = (state == ST_DONE) && (owner == OWN_I);

  assign bus.o_dc_fill_we   = vld_p1 && (owner == OWN_D);
  assign bus.o_dc_fill_idx  = (owner == OWN_D) ? fill_idx_p1 : '0;
  assign bus.o_dc_fill_data = (owner == OWN_D) ? fill_data_p1 : '0;
  assign bus.o_dc_done      = (state == ST_DONE) && (owner == OWN_D);

endmodule

// File: tb/tb_miss_refill_arbiter.sv
// Directed bench for miss_refill_arbiter. A small memory responder grants
// after gnt_delay cycles and returns data rv_delay cycles after the grant;
// the word at address a reads back as a + 0x1000_0000. Cycle numbers count
// negedges after the request is driven, so cycle 0 is the IDLE sampling cycle.
module tb_miss_refill_arbiter;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  miss_refill_arbiter_if #(.IDX_W(2)) bus ();

  miss_refill_arbiter #(.LINE_WORDS(4), .IDX_W(2)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int gnt_delay = 0;
  int rv_delay  = 1;
  int gw_cnt    = 0;
  int rv_cnt    = 0;
  bit rv_pend   = 0;
  logic [31:0] rv_addr;
  bit ic_hold = 0;
  bit dc_hold = 0;

  logic [31:0] mem_addr_log [16];
  logic        mem_we_log   [16];
  logic [31:0] mem_wdata_log[16];
  int          n_mem;
  int          ic_fc[16];
  logic [1:0]  ic_fi[16];
  logic [31:0] ic_fd[16];
  int          n_ic;
  int          dc_fc[16];
  logic [1:0]  dc_fi[16];
  logic [31:0] dc_fd[16];
  int          n_dc;
  int          ic_done_cyc, dc_done_cyc, n_ic_done, n_dc_done;

  task automatic clear_log();
    n_mem = 0; n_ic = 0; n_dc = 0;
    n_ic_done = 0; n_dc_done = 0;
    ic_done_cyc = -1; dc_done_cyc = -1;
    cyc = 0; gw_cnt = 0; rv_pend = 0;
  endtask

  // One clock: sample outputs at negedge, log events, drive memory response.
  task automatic cycle();
    @(negedge Clk);
    cyc++;
    bus.i_mem_gnt    = 1'b0;
    bus.i_mem_rvalid = 1'b0;
    bus.i_mem_rdata  = '0;
    if (bus.o_ic_fill_we && n_ic < 16) begin
      ic_fc[n_ic] = cyc; ic_fi[n_ic] = bus.o_ic_fill_idx; ic_fd[n_ic] = bus.o_ic_fill_data; n_ic++;
    end
    if (bus.o_dc_fill_we && n_dc < 16) begin
      dc_fc[n_dc] = cyc; dc_fi[n_dc] = bus.o_dc_fill_idx; dc_fd[n_dc] = bus.o_dc_fill_data; n_dc++;
    end
    if (bus.o_ic_done) begin
      n_ic_done++; ic_done_cyc = cyc;
      if (!ic_hold) bus.i_ic_req = 1'b0;
    end
    if (bus.o_dc_done) begin
      n_dc_done++; dc_done_cyc = cyc;
      if (!dc_hold) bus.i_dc_req = 1'b0;
    end
    if (rv_pend) begin
      if (rv_cnt == 0) begin
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = rv_addr + 32'h1000_0000;
        rv_pend = 0;
      end else begin
        rv_cnt--;
      end
    end
    if (bus.o_mem_req) begin
      if (gw_cnt < gnt_delay) begin
        gw_cnt++;
      end else begin
        gw_cnt = 0;
        bus.i_mem_gnt = 1'b1;
        if (n_mem < 16) begin
          mem_addr_log[n_mem]  = bus.o_mem_addr;
          mem_we_log[n_mem]    = bus.o_mem_we;
          mem_wdata_log[n_mem] = bus.o_mem_wdata;
          n_mem++;
        end
        if (!bus.o_mem_we) begin
          rv_pend = 1; rv_cnt = rv_delay - 1; rv_addr = bus.o_mem_addr;
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [201:0] outs;
    bus.i_ic_req = 0; bus.i_ic_addr = '0;
    bus.i_dc_req = 0; bus.i_dc_we = 0; bus.i_dc_addr = '0; bus.i_dc_wdata = '0;
    bus.i_mem_gnt = 0; bus.i_mem_rvalid = 0; bus.i_mem_rdata = '0;
    Rst = 1'b0;
    repeat (2) @(negedge Clk);
    outs = {bus.o_mem_req, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata,
            bus.o_ic_fill_we, bus.o_ic_fill_idx, bus.o_ic_fill_data, bus.o_ic_done,
            bus.o_dc_fill_we, bus.o_dc_fill_idx, bus.o_dc_fill_data, bus.o_dc_done};
    checks++;
    if (outs !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h want=0", outs);
    end
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    checks++;
    if (bus.o_mem_req !== 1'b0) begin
      failures++; $display("FAIL idle_no_req got=%b want=0", bus.o_mem_req);
    end
  endtask

  task automatic test_i_refill();
    clear_log();
    bus.i_ic_addr = 32'h0000_1234; bus.i_ic_req = 1'b1;
    repeat (11) cycle();
    checks++;
    if (n_mem !== 4) begin failures++; $display("FAIL t1_nmem got=%0d want=4", n_mem); end
    for (int k = 0; k < 4 && k < n_mem; k++) begin
      checks++;
      if (mem_addr_log[k] !== 32'h0000_1230 + 32'(4*k) || mem_we_log[k] !== 1'b0) begin
        failures++;
        $display("FAIL t1_addr[%0d] got=%h we=%b want=%h we=0", k, mem_addr_log[k], mem_we_log[k], 32'h1230 + 32'(4*k));
      end
    end
    checks++;
    if (n_ic !== 4) begin failures++; $display("FAIL t1_nfill got=%0d want=4", n_ic); end
    for (int k = 0; k < 4 && k < n_ic; k++) begin
      checks++;
      if (ic_fi[k] !== 2'(k) || ic_fd[k] !== 32'h1000_1230 + 32'(4*k) || ic_fc[k] !== 3 + 2*k) begin
        failures++;
        $display("FAIL t1_fill[%0d] got idx=%0d data=%h cyc=%0d want idx=%0d data=%h cyc=%0d",
                 k, ic_fi[k], ic_fd[k], ic_fc[k], k, 32'h1000_1230 + 32'(4*k), 3 + 2*k);
      end
    end
    checks++;
    if (ic_done_cyc !== 9 || n_ic_done !== 1 || n_dc !== 0) begin
      failures++;
      $display("FAIL t1_done got cyc=%0d n=%0d dcfills=%0d want cyc=9 n=1 dcfills=0", ic_done_cyc, n_ic_done, n_dc);
    end
  endtask

  task automatic test_priority();
    clear_log();
    bus.i_dc_we = 1'b0; bus.i_dc_addr = 32'h0000_2000;
    bus.i_ic_addr = 32'h0000_4010;
    bus.i_dc_req = 1'b1; bus.i_ic_req = 1'b1;
    repeat (21) cycle();
    checks++;
    if (n_mem !== 8) begin failures++; $display("FAIL t2_nmem got=%0d want=8", n_mem); end
    for (int k = 0; k < 4 && k + 4 <= n_mem; k++) begin
      checks++;
      if (mem_addr_log[k] !== 32'h0000_2000 + 32'(4*k) || mem_addr_log[k+4] !== 32'h0000_4010 + 32'(4*k)) begin
        failures++;
        $display("FAIL t2_addr[%0d] got d=%h i=%h want d=%h i=%h", k, mem_addr_log[k], mem_addr_log[k+4],
                 32'h2000 + 32'(4*k), 32'h4010 + 32'(4*k));
      end
    end
    checks++;
    if (n_dc !== 4 || dc_done_cyc !== 9 || (n_dc == 4 && dc_fc[3] !== 9)) begin
      failures++; $display("FAIL t2_dside got fills=%0d done=%0d want fills=4 done=9", n_dc, dc_done_cyc);
    end
    checks++;
    if (n_ic !== 4 || ic_fc[0] !== 13 || ic_done_cyc !== 19 || ic_fd[0] !== 32'h1000_4010) begin
      failures++;
      $display("FAIL t2_iside got fills=%0d first=%0d data=%h done=%0d want fills=4 first=13 data=10004010 done=19",
               n_ic, ic_fc[0], ic_fd[0], ic_done_cyc);
    end
  endtask

  task automatic test_store();
    clear_log();
    gnt_delay = 5;
    bus.i_dc_we = 1'b1; bus.i_dc_addr = 32'h0000_3007; bus.i_dc_wdata = 32'hDEAD_BEEF;
    bus.i_dc_req = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      cycle();
      if (i <= 6) begin
        checks++;
        if ({bus.o_mem_req, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata} !== {2'b11, 32'h0000_3004, 32'hDEAD_BEEF}) begin
          failures++;
          $display("FAIL t3_hold[c%0d] got req=%b we=%b addr=%h wdata=%h want 1 1 00003004 deadbeef",
                   i, bus.o_mem_req, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata);
        end
      end else begin
        checks++;
        if (bus.o_dc_done !== 1'b1 || bus.o_mem_req !== 1'b0) begin
          failures++; $display("FAIL t3_done got done=%b req=%b want done=1 req=0", bus.o_dc_done, bus.o_mem_req);
        end
      end
    end
    cycle();
    checks++;
    if (n_mem !== 1 || mem_we_log[0] !== 1'b1 || n_dc !== 0 || n_dc_done !== 1 || dc_done_cyc !== 7) begin
      failures++;
      $display("FAIL t3_summary got nmem=%0d we=%b fills=%0d ndone=%0d donecyc=%0d want 1 1 0 1 7",
               n_mem, mem_we_log[0], n_dc, n_dc_done, dc_done_cyc);
    end
    gnt_delay = 0;
    bus.i_dc_we = 1'b0;
  endtask

  task automatic test_delayed_rvalid();
    rv_delay = 3;
    bus.i_mem_rvalid = 1'b1; bus.i_mem_rdata = 32'hBAD0_BAD0;
    cycle();
    clear_log();
    bus.i_ic_addr = 32'h0000_5008; bus.i_ic_req = 1'b1;
    repeat (19) cycle();
    checks++;
    if (n_ic !== 4 || n_mem !== 4) begin
      failures++; $display("FAIL t4_counts got fills=%0d reqs=%0d want 4 4", n_ic, n_mem);
    end
    for (int k = 0; k < 4 && k < n_ic; k++) begin
      checks++;
      if (ic_fi[k] !== 2'(k) || ic_fd[k] !== 32'h1000_5000 + 32'(4*k) || ic_fc[k] !== 5 + 4*k) begin
        failures++;
        $display("FAIL t4_fill[%0d] got idx=%0d data=%h cyc=%0d want idx=%0d data=%h cyc=%0d",
                 k, ic_fi[k], ic_fd[k], ic_fc[k], k, 32'h1000_5000 + 32'(4*k), 5 + 4*k);
      end
    end
    checks++;
    if (ic_done_cyc !== 17 || n_ic_done !== 1) begin
      failures++; $display("FAIL t4_done got cyc=%0d n=%0d want cyc=17 n=1", ic_done_cyc, n_ic_done);
    end
    rv_delay = 1;
  endtask

  task automatic test_async_reset();
    logic [201:0] outs;
    clear_log();
    bus.i_ic_addr = 32'h0000_6000; bus.i_ic_req = 1'b1;
    repeat (5) cycle();
    checks++;
    if (n_ic !== 2) begin failures++; $display("FAIL t5_prefill got=%0d want=2", n_ic); end
    #2;
    Rst = 1'b0;
    #1;
    outs = {bus.o_mem_req, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata,
            bus.o_ic_fill_we, bus.o_ic_fill_idx, bus.o_ic_fill_data, bus.o_ic_done,
            bus.o_dc_fill_we, bus.o_dc_fill_idx, bus.o_dc_fill_data, bus.o_dc_done};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL t5_async_clear got=%h want=0", outs); end
    bus.i_ic_req = 1'b0; bus.i_mem_gnt = 1'b0; bus.i_mem_rvalid = 1'b0;
    rv_pend = 0; gw_cnt = 0;
    repeat (2) cycle();
    Rst = 1'b1;
    clear_log();
    bus.i_dc_we = 1'b0; bus.i_dc_addr = 32'h0000_7000; bus.i_dc_req = 1'b1;
    repeat (11) cycle();
    checks++;
    if (n_dc !== 4 || n_ic !== 0 || dc_done_cyc !== 9 || n_mem !== 4) begin
      failures++;
      $display("FAIL t5_restart got dfills=%0d ifills=%0d done=%0d reqs=%0d want 4 0 9 4", n_dc, n_ic, dc_done_cyc, n_mem);
    end
    checks++;
    if (dc_fi[0] !== 2'd0 || dc_fd[0] !== 32'h1000_7000 || mem_addr_log[0] !== 32'h0000_7000) begin
      failures++;
      $display("FAIL t5_first got idx=%0d data=%h addr=%h want 0 10007000 00007000", dc_fi[0], dc_fd[0], mem_addr_log[0]);
    end
  endtask

  task automatic test_back_to_back();
    clear_log();
    dc_hold = 1;
    bus.i_dc_we = 1'b0; bus.i_dc_addr = 32'h0000_8000;
    bus.i_ic_addr = 32'h0000_9000;
    bus.i_dc_req = 1'b1; bus.i_ic_req = 1'b1;
    for (int i = 0; i < 31; i++) begin
      cycle();
      if (n_dc_done >= 1) dc_hold = 0;
    end
    checks++;
    if (n_dc_done !== 2 || dc_done_cyc !== 19 || n_dc !== 8) begin
      failures++; $display("FAIL t6_dtwice got ndone=%0d last=%0d fills=%0d want 2 19 8", n_dc_done, dc_done_cyc, n_dc);
    end
    checks++;
    if (n_mem !== 12 || mem_addr_log[4] !== 32'h0000_8000 || mem_addr_log[8] !== 32'h0000_9000) begin
      failures++;
      $display("FAIL t6_order got reqs=%0d m4=%h m8=%h want 12 00008000 00009000", n_mem, mem_addr_log[4], mem_addr_log[8]);
    end
    checks++;
    if (n_ic !== 4 || ic_fc[0] !== 23 || ic_done_cyc !== 29) begin
      failures++; $display("FAIL t6_iwait got fills=%0d first=%0d done=%0d want 4 23 29", n_ic, ic_fc[0], ic_done_cyc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_i_refill();
    test_priority();
    test_store();
    test_delayed_rvalid();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
